// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//   Operand forwarding and load-use hazard unit at the ID/EX boundary.
//   For each source port it picks the newest in-flight value of the named
//   register from the one-ahead (s1) and two-ahead (s2) instructions. If
//   neither has it, the register-file data is used. The chosen operands are
//   registered into EX. A load in s1 whose result a used port needs causes a
//   single stall cycle and a bubble into EX. Two saturating counters track
//   forwarding and stall events.
//
// Ports
//   CLK, RST_n              clock (rising edge), async active-low reset
//   id_valid                instruction in ID is valid
//   id_rs / id_use          per-port source register and "really reads it" flag
//   id_rdata                per-port register-file read data
//   flush                   kill the instruction entering EX
//   s1_*                    one-ahead instruction: valid, regwr, rd, result
//                           source select and raw result candidates
//   s2_*                    two-ahead instruction: valid, regwr, rd, final data
//   ex_op / ex_valid        registered operands and valid for EX
//   stall                   combinational; hold PC and IF/ID this cycle
//   fwd_cnt / stall_cnt     saturating event counters
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NPORTS = 2
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic                   id_valid,
  input  logic [NPORTS*AW-1:0]   id_rs,
  input  logic [NPORTS-1:0]      id_use,
  input  logic [NPORTS*XLEN-1:0] id_rdata,
  input  logic                   flush,
  input  logic                   s1_valid,
  input  logic                   s1_regwr,
  input  logic [AW-1:0]          s1_rd,
  input  logic [1:0]             s1_sel,
  input  logic [XLEN-1:0]        s1_alu,
  input  logic [XLEN-1:0]        s1_pc4,
  input  logic                   s1_cmp,
  input  logic                   s2_valid,
  input  logic                   s2_regwr,
  input  logic [AW-1:0]          s2_rd,
  input  logic [XLEN-1:0]        s2_wdata,
  output logic [NPORTS*XLEN-1:0] ex_op,
  output logic                   ex_valid,
  output logic                   stall,
  output logic [15:0]            fwd_cnt,
  output logic [15:0]            stall_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_CMP  = 2'b11;

  state_t state, state_nxt;

  logic [XLEN-1:0]        s1_value;
  logic                   s1_is_load;
  logic [NPORTS-1:0]      hit1, hit2, fwd1, fwd2;
  logic [NPORTS*XLEN-1:0] op_sel;
  logic                   luse;
  logic                   capture;
  logic                   fwd_event;

  // Result of the one-ahead instruction as it would be written back. A load
  // has no data yet, so it is never forwarded from s1.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    s1_value   = '0;
    s1_is_load = 1'b0;
    unique case (s1_sel)
      SEL_ALU:  s1_value = s1_alu;
      SEL_PC4:  s1_value = s1_pc4;
      SEL_CMP:  s1_value = {{(XLEN-1){1'b0}}, s1_cmp};
      SEL_LOAD: s1_is_load = 1'b1;
      default:  s1_value = '0;
    endcase
  end

  // Per-port hit detection and operand select. Register 0 never matches, so
  // it always takes the register-file value, which is hard-wired zero.
  always_comb begin
    hit1   = '0;
    hit2   = '0;
    fwd1   = '0;
    fwd2   = '0;
    op_sel = id_rdata;
    for (int p = 0; p < NPORTS; p++) begin
      hit1[p] = s1_valid && s1_regwr && (s1_rd == id_rs[p*AW +: AW]) &&
                (id_rs[p*AW +: AW] != '0);
      hit2[p] = s2_valid && s2_regwr && (s2_rd == id_rs[p*AW +: AW]) &&
                (id_rs[p*AW +: AW] != '0);
      // A load hit in s1 is not forwardable and falls through to s2 / RF.
      fwd1[p] = hit1[p] && !s1_is_load;
      fwd2[p] = hit2[p] && !fwd1[p];
      if (fwd1[p])
        op_sel[p*XLEN +: XLEN] = s1_value;
      else if (fwd2[p])
        op_sel[p*XLEN +: XLEN] = s2_wdata;
    end
  end

  // Load-use only fires in RUN, so the STALL cycle can never re-stall. Flush
  // dominates. The RST_n term keeps stall low while reset is held.
  assign luse  = RST_n && id_valid && (state == RUN) && !flush &&
                 (|(id_use & hit1 & {NPORTS{s1_is_load}}));
  assign stall = luse;

  assign capture   = !flush && !luse;
  assign fwd_event = capture && id_valid && (|(id_use & (fwd1 | fwd2)));

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (luse) state_nxt = STALL;
      STALL:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // On a bubble the operand register is held; only the valid bit drops.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ex_op    <= '0;
      ex_valid <= 1'b0;
    end else if (capture) begin
      ex_op    <= op_sel;
      ex_valid <= id_valid;
    end else begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      fwd_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (fwd_event && (fwd_cnt != 16'hFFFF))
        fwd_cnt <= fwd_cnt + 16'd1;
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
